// File: rtl/tx_sched_pkg.sv
// Shared constants for the transmit word scheduler: source count, select width, FSM encodings.
package tx_sched_pkg;

  localparam int unsigned N_SRC = 16;
  localparam int unsigned SEL_W = 4;
  localparam int unsigned ST_W  = 2;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_SEND = 2'd1;
  localparam logic [ST_W-1:0] ST_ACK  = 2'd2;

endpackage : tx_sched_pkg

// File: rtl/rr_pick16.sv
// Round-robin picker: first eligible index after 'last', wrapping 15 -> 0.
module rr_pick16
  import tx_sched_pkg::*;
(
  input  logic [N_SRC-1:0] eligible,
  input  logic [SEL_W-1:0] last,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Scan from the farthest offset down so the nearest eligible index after 'last' is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = int'(N_SRC); k >= 1; k--) begin
      cand = last + SEL_W'(k);
      if (eligible[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule : rr_pick16

// File: rtl/tx_word_scheduler.sv
// Schedules one word at a time from 16 sources onto a single transmitter using round-robin
// arbitration; drives the external mux select, handshakes with the transmitter and
// returns a one-cycle ack to the source whose word was taken.
module tx_word_scheduler
  import tx_sched_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] req,
  input  logic [N_SRC-1:0] mask,
  input  logic             tx_ready,
  output logic [SEL_W-1:0] sel,
  output logic             tx_valid,
  output logic [N_SRC-1:0] ack,
  output logic             busy,
  output logic [CNT_W-1:0] xfer_count
);

  logic [ST_W-1:0]  state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic             tx_valid_q, tx_valid_d;
  logic [N_SRC-1:0] ack_q, ack_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic             accept;

  rr_pick16 u_pick (
    .eligible (req & mask),
    .last     (last_q),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  assign accept = tx_valid_q & tx_ready;

  // Next-state, select/priority bookkeeping, and registered output decode.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    tx_valid_d = 1'b0;
    ack_d      = '0;
    busy_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          sel_d   = pick_idx;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        // Word is committed: only acceptance moves us on, req/mask changes are ignored.
        if (accept) begin
          state_d = ST_ACK;
          last_d  = sel_q;
          cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    tx_valid_d = (state_d == ST_SEND);
    busy_d     = (state_d != ST_IDLE);
    if (state_d == ST_ACK) begin
      ack_d[sel_d] = 1'b1;
    end
  end

  // State and output registers; reset gives source 0 first priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      last_q     <= SEL_W'(N_SRC - 1);
      tx_valid_q <= 1'b0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      tx_valid_q <= tx_valid_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
    end
  end

  assign sel        = sel_q;
  assign tx_valid   = tx_valid_q;
  assign ack        = ack_q;
  assign busy       = busy_q;
  assign xfer_count = cnt_q;

endmodule : tx_word_scheduler
